axi_burst_mst: RTL and testbench

AXI_BURST_MST -- requirements
Module: axi_burst_mst

---
 rtl/axi_burst_mst_pkg.sv | 9 +
 rtl/axi_burst_mst.sv | 172 +++++++++++++++++
 tb/tb_axi_burst_mst.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_burst_mst_pkg.sv
// axi_burst_mst_pkg: shared FSM states, AXI constants and line-width helper
package axi_burst_mst_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, DONE} state_t;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int RESP_ERR_BIT = 1;
    function automatic int line_w(input int dw, input int beats);
        return dw * beats;
    endfunction
endpackage

// File: rtl/axi_burst_mst.sv
// axi_burst_mst: moves one cache line per request as a single AXI4 INCR burst
module axi_burst_mst
    import axi_burst_mst_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int BEATS = 16,
    localparam int LINE_W = line_w(DW, BEATS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [AW-1:0]     req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic [AW-1:0]     M_AXI_AWADDR,
    output logic [7:0]        M_AXI_AWLEN,
    output logic [2:0]        M_AXI_AWSIZE,
    output logic [1:0]        M_AXI_AWBURST,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [DW-1:0]     M_AXI_WDATA,
    output logic [DW/8-1:0]   M_AXI_WSTRB,
    output logic              M_AXI_WLAST,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [AW-1:0]     M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DW-1:0]     M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);
    localparam int OW = $clog2(LINE_W / 8);
    localparam int IW = $clog2(BEATS);
    localparam int CW = IW + 1;

    state_t state, state_n;
    logic [CW-1:0] beat_cnt, beat_cnt_n;
    logic err, err_n, aw_done, aw_done_n, w_done, w_done_n;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wbuf [BEATS];
    logic [LINE_W-1:0] rbuf, rbuf_n;
    logic [IW-1:0] beat_idx;
    logic last_slot, req_hs, ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic unused;

    assign beat_idx  = beat_cnt[IW-1:0];
    assign last_slot = beat_cnt == CW'(BEATS - 1);
    assign req_hs = req_valid & req_ready;
    assign ar_hs  = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs   = M_AXI_RVALID & M_AXI_RREADY;
    assign aw_hs  = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs   = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs   = M_AXI_BVALID & M_AXI_BREADY;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWLEN   = 8'(BEATS - 1);
    assign M_AXI_ARLEN   = 8'(BEATS - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WDATA   = wbuf[beat_idx];
    assign M_AXI_WLAST   = last_slot;
    assign rsp_err       = err;
    assign unused = ^{req_addr[OW-1:0], M_AXI_RRESP[0], M_AXI_BRESP[0]};

    // next state, beat bookkeeping and fill-line assembly
    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        err_n      = err;
        aw_done_n  = aw_done;
        w_done_n   = w_done;
        rbuf_n     = rbuf;
        case (state)
            IDLE: if (req_hs) begin
                state_n    = req_wr ? WR_ADDR_DATA : RD_ADDR;
                beat_cnt_n = '0;
                err_n      = 1'b0;
                aw_done_n  = 1'b0;
                w_done_n   = 1'b0;
            end
            RD_ADDR: if (ar_hs) state_n = RD_DATA;
            RD_DATA: if (r_hs) begin
                if (!beat_cnt[IW]) rbuf_n[beat_idx*DW +: DW] = M_AXI_RDATA;
                beat_cnt_n = beat_cnt[IW] ? beat_cnt : beat_cnt + 1'b1;
                err_n      = err | M_AXI_RRESP[RESP_ERR_BIT] | (M_AXI_RLAST != last_slot);
                if (M_AXI_RLAST) state_n = DONE;
            end
            WR_ADDR_DATA: begin
                aw_done_n = aw_done | aw_hs;
                w_done_n  = w_done | (w_hs & M_AXI_WLAST);
                if (w_hs && !M_AXI_WLAST) beat_cnt_n = beat_cnt + 1'b1;
                if (aw_done_n && w_done_n) state_n = WR_RESP;
            end
            WR_RESP: if (b_hs) begin
                err_n   = err | M_AXI_BRESP[RESP_ERR_BIT];
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else state <= state_n;
    end

    // handshake outputs registered from the next state so no AXI input reaches an AXI output combinationally
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_ready     <= 1'b1;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
        end else begin
            req_ready     <= state_n == IDLE;
            M_AXI_ARVALID <= state_n == RD_ADDR;
            M_AXI_RREADY  <= state_n == RD_DATA;
            M_AXI_AWVALID <= state_n == WR_ADDR_DATA && !aw_done_n;
            M_AXI_WVALID  <= state_n == WR_ADDR_DATA && !w_done_n;
            M_AXI_BREADY  <= state_n == WR_RESP;
            rsp_valid     <= state_n == DONE;
        end
    end

    // per-transaction counters and flags; the visible fill line only changes on its last beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            beat_cnt  <= '0;
            err       <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            beat_cnt <= beat_cnt_n;
            err      <= err_n;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
            if (state == RD_DATA && r_hs && M_AXI_RLAST) rsp_rdata <= rbuf_n;
        end
    end

    // request capture with the line offset cleared, plus the fill staging buffer
    always_ff @(posedge CLK) begin
        if (req_hs) begin
            addr_q <= {req_addr[AW-1:OW], {OW{1'b0}}};
            for (int k = 0; k < BEATS; k++) wbuf[k] <= req_wdata[k*DW +: DW];
        end
        rbuf <= rbuf_n;
    end
endmodule

// File: tb/tb_axi_burst_mst.sv
// tb_axi_burst_mst: table-driven and randomized checks against an SRAM slave and a line-level model
module tb_axi_burst_mst;
    localparam int AW = 32, DW = 64, BEATS = 16, LW = DW * BEATS;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [63:0] base;
        bit          rnd;
        int          stall;
        int          rerr;
        bit          aw_hold;
        logic [31:0] exp_bus;
        bit          exp_err;
    } vec_t;

    logic CLK = 0, RST;
    logic req_valid, req_ready, req_wr, rsp_valid, rsp_err;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_wdata, rsp_rdata;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;

    int checks = 0, errors = 0;
    logic [63:0] sram [logic [31:0]];
    logic [63:0] model [logic [31:0]];
    logic [LW-1:0] last_fill = '0, cur_wline = '0;
    int stall_pct = 0, rerr_beat = -1;
    bit aw_hold = 0;
    int rd_k = 0, w_k = 0, b_count = 0, ar_count = 0;
    bit rd_active = 0, aw_got = 0, wlast_got = 0, hold_arm = 0, stall_seen = 0;
    logic [31:0] rd_addr, wr_addr, last_araddr;
    logic [12:0] last_ar_fields;
    logic [63:0] stall_wdata, wq[$];
    logic stall_wlast;
    vec_t tbl [17];

    always #5 CLK = ~CLK;

    axi_burst_mst #(.AW(AW), .DW(DW), .BEATS(BEATS)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast), .M_AXI_RVALID(rvalid),
        .M_AXI_RREADY(rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            while (k < BEATS - 1 && act[k*64 +: 64] === exp[k*64 +: 64]) k++;
            $display("FAIL %s beat %0d got %h want %h", name, k, act[k*64 +: 64], exp[k*64 +: 64]);
        end
    endtask

    function automatic logic [63:0] dflt(input logic [31:0] a);
        return {32'h5EED0000, a};
    endfunction

    function automatic logic [63:0] sram_rd(input logic [31:0] a);
        return sram.exists(a) ? sram[a] : dflt(a);
    endfunction

    function automatic logic [LW-1:0] model_line(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < BEATS; k++) begin
            logic [31:0] ba;
            ba = a + 32'(8 * k);
            l[k*64 +: 64] = model.exists(ba) ? model[ba] : dflt(ba);
        end
        return l;
    endfunction

    function automatic bit ok();
        return int'($urandom_range(99)) >= stall_pct;
    endfunction

    // AXI SRAM slave: handshakes observed at negedge, responses driven just after posedge
    initial begin : slave
        logic ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_seen;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(negedge CLK);
            rst_seen = RST;
            ar_hs = arvalid & arready;
            r_hs  = rvalid & rready;
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            b_hs  = bvalid & bready;
            if (rst_seen) begin
                rd_active = 0; rd_k = 0; aw_got = 0; wlast_got = 0; w_k = 0;
                wq.delete(); stall_seen = 0; hold_arm = 0;
            end else begin
                if (stall_seen && wvalid) begin
                    chk("wdata_stable", wdata, stall_wdata);
                    chk("wlast_stable", 64'(wlast), 64'(stall_wlast));
                end
                stall_seen = wvalid & ~wready;
                stall_wdata = wdata;
                stall_wlast = wlast;
                if (hold_arm) begin
                    hold_arm = 0;
                    chk("aw_hold_awvalid", 64'(awvalid), 64'd1);
                    chk("aw_hold_wvalid", 64'(wvalid), 64'd0);
                    chk("aw_hold_no_aw", 64'(aw_got), 64'd0);
                end
                if (aw_hs) begin
                    wr_addr = awaddr;
                    aw_got = 1;
                    chk("aw_fields", {51'd0, awlen, awsize, awburst}, {51'd0, 8'd15, 3'd3, 2'b01});
                end
                if (w_hs) begin
                    chk("wlast_pos", 64'(wlast), 64'(w_k == BEATS - 1));
                    chk("wstrb", 64'(wstrb), 64'hFF);
                    chk("wdata", wdata, cur_wline[w_k*64 +: 64]);
                    wq.push_back(wdata);
                    w_k++;
                    if (wlast) begin
                        wlast_got = 1;
                        hold_arm = aw_hold;
                    end
                end
                if (ar_hs) begin
                    last_araddr = araddr;
                    last_ar_fields = {arlen, arsize, arburst};
                    rd_addr = araddr;
                    rd_active = 1;
                    rd_k = 0;
                    ar_count++;
                end
                if (r_hs) begin
                    rd_k++;
                    if (rd_k == BEATS) rd_active = 0;
                end
                if (b_hs) begin
                    b_count++;
                    foreach (wq[k]) sram[wr_addr + 32'(8 * k)] = wq[k];
                    wq.delete();
                    aw_got = 0; wlast_got = 0; w_k = 0;
                end
            end
            @(posedge CLK);
            #1;
            if (rst_seen) begin
                arready = 0; rvalid = 0; rlast = 0; rresp = 0; awready = 0; wready = 0; bvalid = 0;
            end else begin
                arready = ok();
                wready = ok();
                awready = aw_hold ? (wlast_got && !aw_got) : ok();
                if (!(rvalid && !r_hs)) begin
                    rvalid = rd_active && ok();
                    rdata = rvalid ? sram_rd(rd_addr + 32'(8 * rd_k)) : '0;
                    rresp = (rvalid && rd_k == rerr_beat) ? 2'b10 : 2'b00;
                    rlast = rvalid && rd_k == BEATS - 1;
                end
                if (!(bvalid && !b_hs)) bvalid = aw_got && wlast_got && ok();
            end
        end
    end

    task automatic issue(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wl, input bit hold);
        int n;
        req_wr = wr; req_addr = addr; req_wdata = wl; req_valid = 1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(n), 64'd0);
        @(posedge CLK);
        #1;
        if (!hold) req_valid = 0;
    endtask

    task automatic wait_rsp();
        int n, busy;
        n = 0; busy = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!rsp_valid && req_ready) busy++;
        end while (!rsp_valid && n < 2000);
        chk("rsp_seen", 64'(rsp_valid), 64'd1);
        chk("req_ready_busy", 64'(busy), 64'd0);
    endtask

    task automatic run(input vec_t v, input bit hold);
        logic [LW-1:0] wl;
        int bc0, ac0;
        for (int k = 0; k < BEATS; k++) wl[k*64 +: 64] = v.rnd ? {$urandom, $urandom} : v.base + 64'(k);
        cur_wline = wl; stall_pct = v.stall; aw_hold = v.aw_hold; rerr_beat = v.rerr;
        bc0 = b_count; ac0 = ar_count;
        issue(v.wr, v.addr, wl, hold);
        wait_rsp();
        if (v.wr) begin
            for (int k = 0; k < BEATS; k++) model[v.exp_bus + 32'(8 * k)] = wl[k*64 +: 64];
            chk("awaddr", 64'(wr_addr), 64'(v.exp_bus));
            chk("b_handshakes", 64'(b_count - bc0), 64'd1);
        end else begin
            last_fill = model_line(v.exp_bus);
            chk("araddr", 64'(last_araddr), 64'(v.exp_bus));
            chk("ar_fields", 64'(last_ar_fields), {51'd0, 8'd15, 3'd3, 2'b01});
            chk("ar_count", 64'(ar_count - ac0), 64'd1);
            chk("r_beats", 64'(rd_k), 64'(BEATS));
        end
        chk("rsp_err", 64'(rsp_err), 64'(v.exp_err));
        chk_line("rsp_rdata", rsp_rdata, last_fill);
        @(negedge CLK);
        chk("rsp_pulse", 64'(rsp_valid), 64'd0);
        chk("req_ready_after", 64'(req_ready), 64'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_valids"}, {58'd0, arvalid, rready, awvalid, wvalid, bready, rsp_valid}, 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk_line({tag, "_rsp_rdata"}, rsp_rdata, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses;
        vec_t bb;
        RST = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        for (int k = 0; k < BEATS; k++) begin
            sram[32'h1000 + 32'(8 * k)] = 64'h100 + 64'(k);
            model[32'h1000 + 32'(8 * k)] = 64'h100 + 64'(k);
        end
        tbl[0] = '{0, 32'h1000, 64'h0,    0, 0,  -1, 0, 32'h1000, 0};
        tbl[1] = '{1, 32'h2040, 64'hAA00, 0, 40, -1, 0, 32'h2000, 0};
        tbl[2] = '{0, 32'h2040, 64'h0,    0, 30, -1, 0, 32'h2000, 0};
        tbl[3] = '{1, 32'h3000, 64'hBB00, 0, 20, -1, 1, 32'h3000, 0};
        tbl[4] = '{0, 32'h1000, 64'h0,    0, 0,   3, 0, 32'h1000, 1};
        for (int i = 5; i < 17; i++) begin
            tbl[i].wr = bit'($urandom_range(1));
            tbl[i].addr = 32'h4000 + 32'($urandom_range(7)) * 128 + 32'($urandom_range(127));
            tbl[i].base = 64'h0;
            tbl[i].rnd = 1;
            tbl[i].stall = int'($urandom_range(60));
            tbl[i].rerr = (!tbl[i].wr && $urandom_range(3) == 0) ? int'($urandom_range(15)) : -1;
            tbl[i].aw_hold = tbl[i].wr && $urandom_range(3) == 0;
            tbl[i].exp_bus = tbl[i].addr & ~32'h7F;
            tbl[i].exp_err = tbl[i].rerr >= 0;
        end
        repeat (3) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        chk_idle_outputs("reset");

        for (int i = 0; i < 17; i++) run(tbl[i], 0);

        bb = '{0, 32'h2000, 64'h0, 0, 10, -1, 0, 32'h2000, 0};
        run(bb, 1);
        bb.addr = 32'h1010; bb.exp_bus = 32'h1000;
        run(bb, 0);

        stall_pct = 20; rerr_beat = -1; aw_hold = 0;
        issue(0, 32'h1000, '0, 0);
        n = 0;
        while (rd_k < 7 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("reset_trigger", 64'(rd_k >= 7), 64'd1);
        @(posedge CLK);
        #1 RST = 1;
        @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        chk_idle_outputs("midreset");
        last_fill = '0;
        pulses = 0;
        repeat (10) begin
            @(negedge CLK);
            if (rsp_valid) pulses++;
        end
        chk("no_rsp_after_reset", 64'(pulses), 64'd0);
        bb = '{0, 32'h1000, 64'h0, 0, 25, -1, 0, 32'h1000, 0};
        run(bb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
